// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Chain lengths per tile type and the counter-width helper live here.
package ccff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_DONE,
    ST_ERR
  } ccff_state_e;

  // cby/cbx: nine 6-bit plus two 2-bit mux memories; sb is the wider switch block
  localparam int CBY_CHAIN_LEN = 58;
  localparam int CBX_CHAIN_LEN = 58;
  localparam int SB_CHAIN_LEN  = 80;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer for the chain loader: holds one config word, tracks remaining
// bits and the word index, and raises cfg_ready for gapless streaming.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CBY_CHAIN_LEN,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              flush,
  input  logic              en,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  input  logic              cfg_last,
  output logic              cfg_ready,
  output logic              bit_vld,
  output logic              bit_val,
  output logic              last_ok,
  output logic              last_early
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int TAIL_BITS = (CHAIN_LEN % WORD_W == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
  localparam int RW        = cnt_w(WORD_W);
  localparam int NW        = cnt_w(NWORDS);

  logic [WORD_W-1:0] sbuf;
  logic [RW-1:0]     rem;
  logic [NW-1:0]     wcnt;
  logic              hs;
  logic              final_word;
  logic [RW-1:0]     nbits;

  assign final_word = (wcnt == NW'(NWORDS - 1));
  assign cfg_ready  = en && (rem <= RW'(1)) && (wcnt < NW'(NWORDS));
  assign hs         = cfg_valid && cfg_ready;
  assign last_early = hs && cfg_last && !final_word;
  assign last_ok    = hs && cfg_last && final_word;
  assign nbits      = final_word ? RW'(TAIL_BITS) : RW'(WORD_W);

  // An empty buffer forwards bit 0 of the arriving word straight to the head
  assign bit_vld = en && !last_early && ((rem != '0) || hs);
  assign bit_val = (rem != '0) ? sbuf[0] : cfg_data[0];

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sbuf <= '0;
      rem  <= '0;
      wcnt <= '0;
    end else if (flush || last_early) begin
      rem  <= '0;
      wcnt <= '0;
    end else if (hs) begin
      wcnt <= wcnt + NW'(1);
      if (rem == '0) begin
        sbuf <= cfg_data >> 1;
        rem  <= nbits - RW'(1);
      end else begin
        sbuf <= cfg_data;
        rem  <= nbits;
      end
    end else if (rem != '0) begin
      sbuf <= sbuf >> 1;
      rem  <= rem - RW'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises config words onto a tile's ccff chain,
// supports clear, flags framing errors and tracks parity of displaced bits.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CBY_CHAIN_LEN,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              clear,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  input  logic              cfg_last,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              tail_parity
);

  localparam int CW = cnt_w(CHAIN_LEN);

  ccff_state_e state;
  logic [CW-1:0] bcnt;
  logic          got_last;
  logic          start_acc;
  logic          bit_vld, bit_val, last_ok, last_early;

  assign start_acc = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});

  ccff_word_serializer #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_ser (
    .prog_clk  (prog_clk),
    .pReset_n  (pReset_n),
    .flush     (start_acc),
    .en        (state == ST_LOAD),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_last  (cfg_last),
    .cfg_ready (cfg_ready),
    .bit_vld   (bit_vld),
    .bit_val   (bit_val),
    .last_ok   (last_ok),
    .last_early(last_early)
  );

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state         <= ST_IDLE;
      bcnt          <= '0;
      got_last      <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      tail_parity   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      // The tail bit is displaced by the edge that ends a shifting cycle
      if (ccff_shift_en) tail_parity <= tail_parity ^ ccff_tail;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            bcnt        <= '0;
            got_last    <= 1'b0;
            tail_parity <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            if (clear) begin
              state         <= ST_CLEAR;
              ccff_shift_en <= 1'b1;
              bcnt          <= CW'(1);
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (last_early) begin
            state <= ST_ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else if (bcnt == CW'(CHAIN_LEN)) begin
            state <= got_last ? ST_DONE : ST_ERR;
            busy  <= 1'b0;
            done  <= got_last;
            err   <= !got_last;
          end else begin
            if (bit_vld) begin
              ccff_head     <= bit_val;
              ccff_shift_en <= 1'b1;
              bcnt          <= bcnt + CW'(1);
            end
            if (last_ok) got_last <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (bcnt == CW'(CHAIN_LEN)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ccff_shift_en <= 1'b1;
            bcnt          <= bcnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: driver pushes expected head bits and
// per-operation results; a negedge monitor pops and compares them.
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  localparam int CL = 58;
  localparam int WW = 8;

  typedef logic [7:0][WW-1:0] words_t;
  typedef struct {
    logic          done;
    logic          err;
    logic          par_chk;
    logic          par;
    logic          chain_chk;
    logic [CL-1:0] chain;
    int            nshift;
    logic          run_chk;
  } op_t;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b1;
  logic          start = 1'b0, clear = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0, cfg_last = 1'b0;
  logic          cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic          busy, done, err, tail_parity;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .clear(clear),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last),
    .cfg_ready(cfg_ready), .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
    .ccff_tail(ccff_tail), .busy(busy), .done(done), .err(err),
    .tail_parity(tail_parity)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural target chain: index 0 is the head flop, CL-1 the tail flop
  logic [CL-1:0] chain = '0;
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  op_t  op_q[$];
  logic exp_bits[$];
  int   checks = 0, errors = 0;
  int   nshift = 0, cur_run = 0, max_run = 0;
  logic prev_fin = 1'b0;
  words_t P, ONES, Z1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CL-1:0] chain_of(input words_t w);
    logic [CL-1:0] c;
    for (int k = 0; k < CL; k++) c[CL-1-k] = w[k/WW][k%WW];
    return c;
  endfunction

  task automatic push_stream(input words_t w, input int nbits);
    for (int k = 0; k < nbits; k++) exp_bits.push_back(w[k/WW][k%WW]);
  endtask

  task automatic push_op(input logic d, input logic e, input logic pc, input logic p,
                         input logic cc, input logic [CL-1:0] c, input int n, input logic rc);
    op_t o;
    o.done = d; o.err = e; o.par_chk = pc; o.par = p;
    o.chain_chk = cc; o.chain = c; o.nshift = n; o.run_chk = rc;
    op_q.push_back(o);
  endtask

  task automatic wait_fin();
    int tmo = 0;
    while (!(done || err) && tmo < 300) begin @(negedge prog_clk); tmo++; end
    if (tmo >= 300) chk("fin_timeout", done | err, 1);
    @(negedge prog_clk);
  endtask

  task automatic run_load(input words_t w, input int nw, input int last_idx,
                          input bit starve, input bit poke);
    start = 1'b1; clear = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    for (int i = 0; i < nw; i++) begin
      int tmo = 0;
      cfg_data = w[i]; cfg_last = (i == last_idx); cfg_valid = 1'b1;
      if (poke && i == 3) begin start = 1'b1; clear = 1'b1; end
      while (!(cfg_ready && cfg_valid) && tmo < 100) begin
        @(negedge prog_clk);
        tmo++;
        if (starve) cfg_valid = ~cfg_valid;
      end
      if (tmo >= 100) begin chk("ready_timeout", cfg_ready, 1); break; end
      @(negedge prog_clk);
      start = 1'b0; clear = 1'b0;
      if (i == 0 && !starve) chk("first_bit_lat", {ccff_shift_en, ccff_head}, {1'b1, w[0][0]});
      if (i == last_idx && i < 7) chk("early_err_next", {err, ccff_shift_en}, 2'b10);
      if (starve) begin cfg_valid = 1'b0; @(negedge prog_clk); end
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
    wait_fin();
  endtask

  task automatic run_clear();
    start = 1'b1; clear = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; clear = 1'b0;
    chk("clear_first_lat", ccff_shift_en, 1);
    wait_fin();
  endtask

  // Monitor: every shift cycle pops a head bit; every rise of done/err pops an op
  always @(negedge prog_clk) begin
    if (!pReset_n) begin
      exp_bits.delete(); op_q.delete();
      nshift = 0; cur_run = 0; max_run = 0; prev_fin = 1'b0;
    end else begin
      if (ccff_shift_en) begin
        nshift++; cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (exp_bits.size() == 0) chk("unexpected_shift", ccff_shift_en, 0);
        else chk("head_bit", ccff_head, exp_bits.pop_front());
      end else cur_run = 0;
      if ((done || err) && !prev_fin) begin
        if (op_q.size() == 0) chk("unexpected_finish", done | err, 0);
        else begin
          op_t e;
          e = op_q.pop_front();
          chk("op_done", done, e.done);
          chk("op_err", err, e.err);
          chk("op_busy", busy, 0);
          chk("op_shift_off", ccff_shift_en, 0);
          chk("op_nshift", nshift, e.nshift);
          chk("op_bits_left", exp_bits.size(), 0);
          if (e.run_chk) chk("op_run", max_run, CL);
          if (e.par_chk) chk("op_parity", tail_parity, e.par);
          if (e.chain_chk) chk("op_chain", chain, e.chain);
        end
        exp_bits.delete();
        nshift = 0; max_run = 0;
      end
      prev_fin = done || err;
    end
  end

  initial begin
    P[0] = 8'h01; P[1] = 8'h23; P[2] = 8'h45; P[3] = 8'h67;
    P[4] = 8'h89; P[5] = 8'hAB; P[6] = 8'hCD; P[7] = 8'h03;
    for (int i = 0; i < 8; i++) begin ONES[i] = 8'hFF; Z1[i] = 8'h00; end
    Z1[7] = 8'h02;  // stream bit 57 lands in the head flop: chain = 58'h1

    #2 pReset_n = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("reset_outs", {cfg_ready, ccff_head, ccff_shift_en, busy, done, err, tail_parity}, 7'b0);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // full load onto an all-zero chain
    push_stream(P, CL); push_op(1, 0, 1, 0, 1, chain_of(P), CL, 1);
    run_load(P, 8, 7, 0, 0);
    // all ones displaces P (27 ones -> parity 1)
    push_stream(ONES, CL); push_op(1, 0, 1, 1, 1, {CL{1'b1}}, CL, 1);
    run_load(ONES, 8, 7, 0, 0);
    // clear displaces 58 ones -> parity 0
    for (int k = 0; k < CL; k++) exp_bits.push_back(1'b0);
    push_op(1, 0, 1, 0, 1, '0, CL, 1);
    run_clear();
    // preload 0x1, then load P over it -> parity 1
    push_stream(Z1, CL); push_op(1, 0, 1, 0, 1, 58'h1, CL, 1);
    run_load(Z1, 8, 7, 0, 0);
    push_stream(P, CL); push_op(1, 0, 1, 1, 1, chain_of(P), CL, 1);
    run_load(P, 8, 7, 0, 0);
    // early last on word 5: words 0..3 minus the residual bit of word 3 = 31 shifts
    push_stream(P, 31); push_op(0, 1, 0, 0, 0, '0, 31, 0);
    run_load(P, 5, 4, 0, 0);
    // recovery after ERR
    push_stream(P, CL); push_op(1, 0, 0, 0, 1, chain_of(P), CL, 1);
    run_load(P, 8, 7, 0, 0);
    // missing last: full shift then ERR; displaces P -> parity 1
    push_stream(P, CL); push_op(0, 1, 1, 1, 1, chain_of(P), CL, 1);
    run_load(P, 8, -1, 0, 0);
    // starvation bubbles, same final contents
    push_stream(P, CL); push_op(1, 0, 1, 1, 1, chain_of(P), CL, 0);
    run_load(P, 8, 7, 1, 0);
    // start(clear) asserted mid-LOAD is ignored
    push_stream(P, CL); push_op(1, 0, 1, 1, 1, chain_of(P), CL, 1);
    run_load(P, 8, 7, 0, 1);

    // reset at shift 30
    push_stream(P, CL);
    start = 1'b1; clear = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int tmo = 0;
      cfg_data = P[i]; cfg_valid = 1'b1;
      while (!cfg_ready && tmo < 100) begin @(negedge prog_clk); tmo++; end
      @(negedge prog_clk);
    end
    cfg_valid = 1'b0;
    begin
      int tmo = 0;
      while (nshift < 30 && tmo < 100) begin @(negedge prog_clk); tmo++; end
      if (tmo >= 100) chk("shift30_timeout", ccff_shift_en, 1);
    end
    pReset_n = 1'b0;
    #1;
    chk("reset_mid_outs", {cfg_ready, ccff_head, ccff_shift_en, busy, done, err, tail_parity}, 7'b0);
    repeat (2) @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    chk("reset_idle_outs", {cfg_ready, ccff_shift_en, busy, done, err}, 5'b0);
    // recovery by clear
    for (int k = 0; k < CL; k++) exp_bits.push_back(1'b0);
    push_op(1, 0, 0, 0, 1, '0, CL, 1);
    run_clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader for the fabric's routing tiles. It takes configuration words from the host-side bitstream source over a valid/ready stream and serialises them onto a tile's `ccff_head`/`ccff_tail` shift chain, one bit per `prog_clk` cycle. It also drives the clock-gate enable for that chain. It sits between the bitstream DMA and the head of a connection-block / switch-block chain. It supports a full load, a clear (shift zeros), error flagging and parity of the displaced chain contents.

## Interface
- `CHAIN_LEN`, 58: number of config flops in the target chain. 58 is the current connection-block chain: nine 6-bit mux memories plus two 2-bit mux memories.
- `WORD_W`, 8: configuration word width.
- `prog_clk`  in  1  programming clock. This is the only clock.
- `pReset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle command. Accepted only in IDLE, DONE or ERR.
- `clear`  in  1  sampled together with `start`. 1 selects a clear operation; 0 selects a load.
- `cfg_data`  in  WORD_W  configuration word. Sent LSB first.
- `cfg_valid`  in  1  word valid.
- `cfg_last`  in  1  marks the final word of the bitstream.
- `cfg_ready`  out  1  word accept. A word transfers when `cfg_valid` and `cfg_ready` are both high.
- `ccff_head`  out  1  serial bit to the chain head.
- `ccff_shift_en`  out  1  enable to the chain's clock gate.
- `ccff_tail`  in  1  serial bit returned from the chain tail.
- `busy`  out  1  high in LOAD and CLEAR.
- `done`  out  1  high in DONE.
- `err`  out  1  high in ERR.
- `tail_parity`  out  1  XOR of all `ccff_tail` bits displaced during the last operation.

## Operation
- **States:** IDLE, LOAD, CLEAR, DONE, ERR.
  - Reset state is IDLE.
  - DONE and ERR are sticky until the next accepted `start`.
- **Commands:**
  - `start` with `clear=0` → LOAD.
  - `start` with `clear=1` → CLEAR.
  - Accepting a command zeroes the bit counter `bcnt` (width $clog2(CHAIN_LEN+1)) and `tail_parity`.
  - `start` while in LOAD or CLEAR is ignored.
- **Word buffer:** one `WORD_W` shift register plus a count of remaining bits.
  - A word holds `WORD_W` valid bits, except the final word.
  - The final word holds `R = CHAIN_LEN mod WORD_W` valid bits (bits [R-1:0]), or `WORD_W` if R = 0. Its upper bits are ignored.
- **LOAD:**
  - Each cycle the buffer holds a bit, that bit is shifted out and `bcnt` increments.
  - `cfg_ready` is high in LOAD when the buffer is empty or holds exactly one bit. This gives gapless streaming when `cfg_valid` is held high.
  - When `bcnt` reaches CHAIN_LEN: go to DONE if the final word carried `cfg_last`, otherwise go to ERR.
  - `cfg_last` on a word that does not complete CHAIN_LEN: go to ERR immediately. That word is not shifted.
  - Data starvation inserts bubbles with `ccff_shift_en=0`. The chain holds its state.
- **CLEAR:**
  - `cfg_ready` stays 0.
  - Shifts CHAIN_LEN zeros, then goes to DONE.
- **Parity:** in every cycle where `ccff_shift_en=1`, `tail_parity ^= ccff_tail`, sampled in that same cycle.
- **Outside LOAD:** `cfg_ready=0` in every state other than LOAD.

## Timing
- **Registered outputs:** `ccff_head` and `ccff_shift_en` are registered and change together. The chain captures `ccff_head` on the `prog_clk` edge that ends a cycle with `ccff_shift_en=1`.
- **Start to first shift:**
  - LOAD: first bit appears 1 cycle after the handshake of the first word.
  - CLEAR: first bit appears 1 cycle after `start`.
- **Operation length:** with no bubbles, `ccff_shift_en` is high for exactly CHAIN_LEN consecutive cycles. DONE is entered in the cycle after the last shift. `busy` drops in that same cycle.
- **Reset values:** all outputs are 0 (`cfg_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `err`, `tail_parity`). Reset state is IDLE.
- **Reset mid-operation:** stops shifting immediately. Chain contents are undefined afterwards. Recovery requires a new LOAD or CLEAR.
- **ERR entry:** `ccff_shift_en=0` in the first cycle of ERR. Any residual buffer bits are discarded.

## Structure
- **Shared package `ccff_pkg`:** state enum `ccff_state_e`, the default CHAIN_LEN constant for each tile type (cby/cbx/sb), and the counter-width function.
- **Sub-module `ccff_word_serializer`:** word buffer, remaining-bit count and `cfg_ready` generation. The FSM, `bcnt` and parity live in the top module.

## Test plan
- **Full load:** defaults, 8 words (last = 0x3, `cfg_last=1`), streamed back-to-back → 58 consecutive `ccff_shift_en` cycles, LSB-first order matches on a 58-flop chain model, `done=1`, `err=0`.
- **Clear then parity:**
  - Load all-ones, then CLEAR → chain reads all zeros.
  - `tail_parity` = 0 (58 ones displaced).
  - Load with chain preloaded as 0x1 → `tail_parity` = 1.
- **Early last:** `cfg_last` on word 5 → ERR next cycle, no shift of word 5, `err=1`. A subsequent `start` recovers to LOAD.
- **Missing last:** 8 words with no `cfg_last` → 58 shifts, then `err=1`.
- **Starvation:** `cfg_valid` toggled 1/0 every cycle → bubbles with `ccff_shift_en=0`, final chain contents identical to the full-load case.
- **Reset and ignored start:** `pReset_n` low at shift 30 → all outputs 0, IDLE. `start` asserted during LOAD → ignored, `bcnt` unaffected.
